// File: rtl/bk_sd_xfer.sv
// bk_sd_xfer: backup-RAM transfer controller.
// Moves cartridge save RAM between the BSRAM buffer and the mounted SD image,
// one sector per hps_io request. Load has priority over save. An ack watchdog
// aborts a stalled transfer and raises a sticky error flag.
//
// Optional feature: define BK_AUTOSAVE_EN to start a save automatically once the
// BSRAM has been written and then left idle for 2^AS_DELAY_W-1 cycles.
//
// Ports:
//   clk_sys      system clock
//   reset        asynchronous active-high reset
//   bk_ena       save image mounted, writable and RAM present
//   ram_mask     backup RAM byte mask (bytes-1), 0 = no RAM
//   load_req     OSD load level (rising edge acts)
//   save_req     OSD save level (rising edge acts)
//   mount_load   pulse at end of ROM download, requests an auto-load
//   img_size_nz  mounted image size is nonzero
//   bsram_wr     BSRAM write strobe (autosave only)
//   sd_ack       hps_io sector acknowledge
//   sd_lba       current sector
//   sd_rd/sd_wr  sector read/write request
//   bk_loading   load in progress (holds core in reset)
//   busy         transfer in progress
//   done         one-cycle pulse on successful completion
//   error        sticky ack-timeout flag
module bk_sd_xfer #(
    parameter int unsigned MASK_W     = 24,
    parameter int unsigned LBA_W      = 32,
    parameter int unsigned SECT_SHIFT = 9,
    parameter int unsigned TO_W       = 24,
    parameter int unsigned AS_DELAY_W = 26
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              bk_ena,
    input  logic [MASK_W-1:0] ram_mask,
    input  logic              load_req,
    input  logic              save_req,
    input  logic              mount_load,
    input  logic              img_size_nz,
    input  logic              bsram_wr,
    input  logic              sd_ack,
    output logic [LBA_W-1:0]  sd_lba,
    output logic              sd_rd,
    output logic              sd_wr,
    output logic              bk_loading,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned LAST_W = MASK_W - SECT_SHIFT;

    typedef enum logic [0:0] {StIdle, StXfer} state_t;

    state_t            state_q, state_d;
    logic [LBA_W-1:0]  lba_q, lba_d;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic              ldg_q, ldg_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              ack_q;
    logic              prev_ld_q, prev_sv_q;

    logic              ld_lvl, sv_lvl, ld_e, sv_e;
    logic              ack_rise, ack_fall;
    logic              mask_nz, ld_start, sv_start, start;
    logic              as_fire;
    logic [LBA_W-1:0]  last;

    assign ld_lvl   = load_req & bk_ena;
    assign sv_lvl   = save_req & bk_ena;
    assign ld_e     = ld_lvl & ~prev_ld_q;
    assign sv_e     = sv_lvl & ~prev_sv_q;
    assign ack_rise = sd_ack & ~ack_q;
    assign ack_fall = ~sd_ack & ack_q;
    assign mask_nz  = (ram_mask != '0);
    assign ld_start = ld_e | (mount_load & img_size_nz & bk_ena);
    assign sv_start = sv_e | as_fire;
    assign start    = (state_q == StIdle) & mask_nz & (ld_start | sv_start);

    // Last sector index: mask bits above the sector offset, zero-extended.
    always_comb begin
        last = '0;
        for (int i = 0; i < LBA_W; i++) begin
            if (i < LAST_W) last[i] = ram_mask[i + SECT_SHIFT];
        end
    end

    always_comb begin
        state_d = state_q;
        lba_d   = lba_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        ldg_d   = ldg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        to_d    = to_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StXfer;
                    lba_d   = '0;
                    rd_d    = ld_start;
                    wr_d    = ~ld_start;
                    ldg_d   = ld_start;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    to_d    = '0;
                end
            end
            StXfer: begin
                to_d = to_q + 1'b1;
                if (to_q == '1) begin
                    // Watchdog expired: abandon the transfer without a done pulse.
                    state_d = StIdle;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    ldg_d   = 1'b0;
                end else begin
                    if (ack_rise) begin
                        rd_d = 1'b0;
                        wr_d = 1'b0;
                        to_d = '0;
                    end
                    if (ack_fall) begin
                        to_d = '0;
                        if (lba_q >= last) begin
                            state_d = StIdle;
                            busy_d  = 1'b0;
                            ldg_d   = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            // bk_loading still holds the transfer direction here.
                            lba_d = lba_q + 1'b1;
                            rd_d  = ldg_q;
                            wr_d  = ~ldg_q;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            lba_q     <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            ldg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            to_q      <= '0;
            ack_q     <= 1'b0;
            prev_ld_q <= 1'b0;
            prev_sv_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lba_q     <= lba_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            ldg_q     <= ldg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            to_q      <= to_d;
            ack_q     <= sd_ack;
            prev_ld_q <= ld_lvl;
            prev_sv_q <= sv_lvl;
        end
    end

`ifdef BK_AUTOSAVE_EN
    logic                  dirty_q, dirty_d;
    logic [AS_DELAY_W-1:0] as_q, as_d;

    assign as_fire = dirty_q & (as_q == '1) & bk_ena & mask_nz;

    always_comb begin
        dirty_d = dirty_q;
        as_d    = as_q;
        // Any save start snapshots the RAM; a completed load makes it clean.
        if (start && !ld_start) dirty_d = 1'b0;
        if (done_d && ldg_q) dirty_d = 1'b0;
        if (bsram_wr && !ldg_q) dirty_d = 1'b1;
        if (bsram_wr || start) begin
            as_d = '0;
        end else if (dirty_q && state_q == StIdle && as_q != '1) begin
            as_d = as_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dirty_q <= 1'b0;
            as_q    <= '0;
        end else begin
            dirty_q <= dirty_d;
            as_q    <= as_d;
        end
    end
`else
    logic unused_as;
    assign as_fire   = 1'b0;
    assign unused_as = bsram_wr & (AS_DELAY_W > 0);
`endif

    assign sd_lba     = lba_q;
    assign sd_rd      = rd_q;
    assign sd_wr      = wr_q;
    assign bk_loading = ldg_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = err_q;

endmodule
